// File: rtl/dma_put_cmd_splitter.sv
// Splits one host-to-FPGA put request into chunk commands bounded by MAX_CHUNK host alignment and PAGE_SIZE memory pages.
// First command 2 cycles after accept, 2 cycles per chunk; stalls while MAX_OUTSTANDING chunks await status.
module dma_put_cmd_splitter #(
  parameter int unsigned     MAX_CHUNK       = 4096,
  parameter longint unsigned PAGE_SIZE       = 2 * 1024 * 1024,
  parameter int unsigned     MAX_OUTSTANDING = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  s_req_valid,
  output logic                  s_req_ready,
  input  logic [159:0]          s_req_data,
  output logic                  m_put_cmd_valid,
  input  logic                  m_put_cmd_ready,
  output logic [159:0]          m_put_cmd_data,
  input  logic                  s_mem_sts_valid,
  input  logic                  s_mem_sts_error,
  output logic                  s_mem_sts_ready,
  output logic                  busy,
  output logic                  req_done,
  output logic [1:0][31:0]      status_reg
);

  localparam logic [63:0] CHUNK_SZ   = 64'(MAX_CHUNK);
  localparam logic [63:0] CHUNK_MASK = 64'(MAX_CHUNK) - 64'd1;
  localparam logic [63:0] PAGE_SZ    = 64'(PAGE_SIZE);
  localparam logic [63:0] PAGE_MASK  = 64'(PAGE_SIZE) - 64'd1;
  localparam logic [7:0]  MAX_OUT    = 8'(MAX_OUTSTANDING);
  localparam logic [32:0] LEN_SAT    = 33'h0_FFFF_FFC0;

  typedef enum logic [2:0] {IDLE, CALC, ISSUE, WAIT_STS, DONE} state_t;

  state_t       state_q, state_d;
  logic         ddr_q, ddr_d;
  logic [62:0]  mem_q, mem_d;
  logic [63:0]  host_q, host_d;
  logic [31:0]  rem_q, rem_d;
  logic [31:0]  chunk_q, chunk_d;
  logic [7:0]   outst_q, outst_d;
  logic [31:0]  issued_q, issued_d;
  logic [31:0]  err_q, err_d;
  logic         req_rdy_q, req_rdy_d;
  logic         cmd_vld_q, cmd_vld_d;
  logic         busy_q, busy_d;
  logic         done_q, done_d;

  logic         req_hs, cmd_hs;
  logic [32:0]  len_sum, len_r;
  logic [63:0]  host_room, page_room;
  logic [31:0]  chunk_c;

  assign req_hs = s_req_valid && req_rdy_q;
  assign cmd_hs = cmd_vld_q && m_put_cmd_ready;

  // Round the request length up to whole 64-byte beats, clamped to the largest 32-bit multiple of 64.
  always_comb begin
    len_sum = {1'b0, s_req_data[31:0]} + 33'd63;
    len_r   = len_sum & ~33'd63;
    if (len_r > LEN_SAT) len_r = LEN_SAT;
  end

  always_comb begin
    host_room = CHUNK_SZ - (host_q & CHUNK_MASK);
    page_room = PAGE_SZ - ({1'b0, mem_q} & PAGE_MASK);
    chunk_c   = rem_q;
    if (host_room < {32'd0, chunk_c}) chunk_c = host_room[31:0];
    if (page_room < {32'd0, chunk_c}) chunk_c = page_room[31:0];
  end

  always_comb begin
    state_d  = state_q;
    ddr_d    = ddr_q;
    mem_d    = mem_q;
    host_d   = host_q;
    rem_d    = rem_q;
    chunk_d  = chunk_q;
    outst_d  = outst_q;
    issued_d = issued_q;
    err_d    = err_q;

    case (state_q)
      IDLE: begin
        if (req_hs) begin
          ddr_d   = s_req_data[159];
          mem_d   = s_req_data[158:96];
          host_d  = s_req_data[95:32];
          rem_d   = len_r[31:0];
          state_d = (len_r == 33'd0) ? DONE : CALC;
        end
      end
      CALC: begin
        chunk_d = chunk_c;
        state_d = ISSUE;
      end
      ISSUE: begin
        if (cmd_hs) begin
          host_d  = host_q + {32'd0, chunk_q};
          mem_d   = mem_q + {31'd0, chunk_q};
          rem_d   = rem_q - chunk_q;
          state_d = (rem_q == chunk_q) ? WAIT_STS : CALC;
        end
      end
      WAIT_STS: begin
        if (outst_q == 8'd0) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (cmd_hs) issued_d = issued_q + 32'd1;

    // A status beat meeting a command handshake cancels out; a beat with nothing outstanding is spurious.
    if (cmd_hs && !s_mem_sts_valid) begin
      outst_d = outst_q + 8'd1;
    end else if (!cmd_hs && s_mem_sts_valid && outst_q != 8'd0) begin
      outst_d = outst_q - 8'd1;
    end

    if (s_mem_sts_valid && (s_mem_sts_error || outst_q == 8'd0) && err_q != 32'hFFFF_FFFF) begin
      err_d = err_q + 32'd1;
    end

    req_rdy_d = (state_d == IDLE);
    busy_d    = (state_d != IDLE);
    done_d    = (state_d == DONE);
    cmd_vld_d = (state_d == ISSUE) && (outst_d < MAX_OUT);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      ddr_q     <= 1'b0;
      mem_q     <= '0;
      host_q    <= '0;
      rem_q     <= '0;
      chunk_q   <= '0;
      outst_q   <= '0;
      issued_q  <= '0;
      err_q     <= '0;
      req_rdy_q <= 1'b0;
      cmd_vld_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      ddr_q     <= ddr_d;
      mem_q     <= mem_d;
      host_q    <= host_d;
      rem_q     <= rem_d;
      chunk_q   <= chunk_d;
      outst_q   <= outst_d;
      issued_q  <= issued_d;
      err_q     <= err_d;
      req_rdy_q <= req_rdy_d;
      cmd_vld_q <= cmd_vld_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign s_req_ready     = req_rdy_q;
  assign m_put_cmd_valid = cmd_vld_q;
  assign m_put_cmd_data  = {ddr_q, mem_q, host_q, chunk_q};
  assign s_mem_sts_ready = 1'b1;
  assign busy            = busy_q;
  assign req_done        = done_q;
  assign status_reg[0]   = issued_q;
  assign status_reg[1]   = err_q;

endmodule

// File: tb/tb_dma_put_cmd_splitter.sv
// Directed bench for dma_put_cmd_splitter: splitting, boundaries, backpressure, outstanding limit, reset.
module tb_dma_put_cmd_splitter;

  logic             clk = 1'b0;
  logic             rst;
  logic             s_req_valid;
  logic             s_req_ready;
  logic [159:0]     s_req_data;
  logic             m_put_cmd_valid;
  logic             m_put_cmd_ready;
  logic [159:0]     m_put_cmd_data;
  logic             s_mem_sts_valid;
  logic             s_mem_sts_error;
  logic             s_mem_sts_ready;
  logic             busy;
  logic             req_done;
  logic [1:0][31:0] status_reg;

  int               n_chk = 0;
  int               n_err = 0;
  int               cmd_cnt = 0;
  int               done_cnt = 0;
  logic             auto_sts = 1'b0;
  logic [159:0]     cmd_log [0:255];

  dma_put_cmd_splitter dut (
    .clk             (clk),
    .rst             (rst),
    .s_req_valid     (s_req_valid),
    .s_req_ready     (s_req_ready),
    .s_req_data      (s_req_data),
    .m_put_cmd_valid (m_put_cmd_valid),
    .m_put_cmd_ready (m_put_cmd_ready),
    .m_put_cmd_data  (m_put_cmd_data),
    .s_mem_sts_valid (s_mem_sts_valid),
    .s_mem_sts_error (s_mem_sts_error),
    .s_mem_sts_ready (s_mem_sts_ready),
    .busy            (busy),
    .req_done        (req_done),
    .status_reg      (status_reg)
  );

  always #5 clk = ~clk;

  function automatic logic [159:0] cmd(input logic d, input logic [62:0] m,
                                       input logic [63:0] h, input logic [31:0] l);
    return {d, m, h, l};
  endfunction

  task automatic chk(input string tag, input logic [159:0] obs, input logic [159:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Samples the settled cycle just before the edge, then advances one clock.
  task automatic tick();
    logic hs;
    hs = m_put_cmd_valid && m_put_cmd_ready;
    if (hs) begin
      if (cmd_cnt < 256) cmd_log[cmd_cnt] = m_put_cmd_data;
      cmd_cnt++;
    end
    if (req_done) done_cnt++;
    @(posedge clk);
    #1;
    if (auto_sts) begin
      s_mem_sts_valid = hs;
      s_mem_sts_error = 1'b0;
    end
  endtask

  task automatic send_req(input logic [159:0] d);
    s_req_data  = d;
    s_req_valid = 1'b1;
    chk("req_ready", 160'(s_req_ready), 160'd1);
    tick();
    s_req_valid = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int d0;
    int n;
    d0 = done_cnt;
    n  = 0;
    while (done_cnt == d0 && n < budget) begin
      tick();
      n++;
    end
    chk(tag, 160'(done_cnt - d0), 160'd1);
  endtask

  initial begin
    int base;
    int d0;
    int n;

    rst = 1'b1;
    s_req_valid = 1'b0;
    s_req_data = '0;
    m_put_cmd_ready = 1'b0;
    s_mem_sts_valid = 1'b0;
    s_mem_sts_error = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_req_ready", 160'(s_req_ready), 160'd0);
    chk("rst_cmd_valid", 160'(m_put_cmd_valid), 160'd0);
    chk("rst_busy", 160'(busy), 160'd0);
    chk("rst_req_done", 160'(req_done), 160'd0);
    chk("rst_status", 160'(status_reg), 160'd0);
    chk("sts_ready", 160'(s_mem_sts_ready), 160'd1);
    rst = 1'b0;
    chk("rel_ready_low", 160'(s_req_ready), 160'd0);
    tick();
    chk("rel_ready_high", 160'(s_req_ready), 160'd1);

    // Two aligned 4 KiB chunks with status returned per command.
    auto_sts = 1'b1;
    m_put_cmd_ready = 1'b1;
    base = cmd_cnt;
    d0 = done_cnt;
    send_req(cmd(1'b0, 63'h0, 64'h0, 32'd8192));
    chk("t1_calc_valid", 160'(m_put_cmd_valid), 160'd0);
    chk("t1_busy", 160'(busy), 160'd1);
    chk("t1_ready_low", 160'(s_req_ready), 160'd0);
    tick();
    chk("t1_first_valid", 160'(m_put_cmd_valid), 160'd1);
    wait_done("t1_done", 60);
    chk("t1_ncmd", 160'(cmd_cnt - base), 160'd2);
    chk("t1_cmd0", cmd_log[base], cmd(1'b0, 63'h0, 64'h0, 32'd4096));
    chk("t1_cmd1", cmd_log[base + 1], cmd(1'b0, 63'h1000, 64'h1000, 32'd4096));
    chk("t1_issued", 160'(status_reg[0]), 160'd2);
    repeat (3) tick();
    chk("t1_one_done", 160'(done_cnt - d0), 160'd1);
    chk("t1_idle_busy", 160'(busy), 160'd0);

    // Host offset not aligned to MAX_CHUNK.
    base = cmd_cnt;
    send_req(cmd(1'b0, 63'h0, 64'h800, 32'd4096));
    wait_done("t2_done", 60);
    chk("t2_ncmd", 160'(cmd_cnt - base), 160'd2);
    chk("t2_cmd0", cmd_log[base], cmd(1'b0, 63'h0, 64'h800, 32'd2048));
    chk("t2_cmd1", cmd_log[base + 1], cmd(1'b0, 63'h800, 64'h1000, 32'd2048));

    // Memory page crossing.
    base = cmd_cnt;
    send_req(cmd(1'b0, 63'h1F_FC00, 64'h0, 32'd4096));
    wait_done("t3_done", 60);
    chk("t3_ncmd", 160'(cmd_cnt - base), 160'd2);
    chk("t3_cmd0", cmd_log[base], cmd(1'b0, 63'h1F_FC00, 64'h0, 32'd1024));
    chk("t3_cmd1", cmd_log[base + 1], cmd(1'b0, 63'h20_0000, 64'h400, 32'd3072));

    // ddr flag kept while the 63-bit address wraps to zero.
    base = cmd_cnt;
    send_req(cmd(1'b1, 63'h7FFF_FFFF_FFFF_F800, 64'h0, 32'd4096));
    wait_done("t3b_done", 60);
    chk("t3b_ncmd", 160'(cmd_cnt - base), 160'd2);
    chk("t3b_cmd0", cmd_log[base], cmd(1'b1, 63'h7FFF_FFFF_FFFF_F800, 64'h0, 32'd2048));
    chk("t3b_cmd1", cmd_log[base + 1], cmd(1'b1, 63'h0, 64'h800, 32'd2048));

    // Zero length completes without a command.
    base = cmd_cnt;
    send_req(cmd(1'b0, 63'h0, 64'h0, 32'd0));
    chk("t4_len0_done", 160'(req_done), 160'd1);
    tick();
    chk("t4_len0_pulse_end", 160'(req_done), 160'd0);
    chk("t4_len0_ready", 160'(s_req_ready), 160'd1);
    chk("t4_len0_ncmd", 160'(cmd_cnt - base), 160'd0);

    // Length 100 rounds up to 128.
    base = cmd_cnt;
    send_req(cmd(1'b0, 63'h40, 64'h80, 32'd100));
    wait_done("t4_len100_done", 40);
    chk("t4_len100_ncmd", 160'(cmd_cnt - base), 160'd1);
    chk("t4_len100_cmd", cmd_log[base], cmd(1'b0, 63'h40, 64'h80, 32'd128));

    // Backpressure: valid and data hold, single command afterwards.
    base = cmd_cnt;
    m_put_cmd_ready = 1'b0;
    send_req(cmd(1'b0, 63'h3000, 64'h5000, 32'd64));
    tick();
    for (int i = 0; i < 10; i++) begin
      chk("t5_hold_valid", 160'(m_put_cmd_valid), 160'd1);
      chk("t5_hold_data", m_put_cmd_data, cmd(1'b0, 63'h3000, 64'h5000, 32'd64));
      tick();
    end
    m_put_cmd_ready = 1'b1;
    wait_done("t5_done", 40);
    chk("t5_ncmd", 160'(cmd_cnt - base), 160'd1);

    // Outstanding limit with no status returned.
    auto_sts = 1'b0;
    s_mem_sts_valid = 1'b0;
    base = cmd_cnt;
    send_req(cmd(1'b0, 63'h0, 64'h0, 32'd131072));
    repeat (60) tick();
    chk("t6_ncmd16", 160'(cmd_cnt - base), 160'd16);
    chk("t6_stalled", 160'(m_put_cmd_valid), 160'd0);
    s_mem_sts_valid = 1'b1;
    s_mem_sts_error = 1'b1;
    tick();
    s_mem_sts_valid = 1'b0;
    s_mem_sts_error = 1'b0;
    chk("t6_unblock", 160'(m_put_cmd_valid), 160'd1);
    repeat (4) tick();
    chk("t6_ncmd17", 160'(cmd_cnt - base), 160'd17);
    chk("t6_stalled_again", 160'(m_put_cmd_valid), 160'd0);
    chk("t6_err_cnt", 160'(status_reg[1]), 160'd1);
    chk("t6_issued", 160'(status_reg[0]), 160'd27);

    // Clear the stalled request, then reset mid-issue with three outstanding.
    rst = 1'b1;
    #1;
    chk("t7a_status_clr", 160'(status_reg), 160'd0);
    repeat (2) tick();
    rst = 1'b0;
    tick();
    base = cmd_cnt;
    send_req(cmd(1'b0, 63'h1_0000, 64'h0, 32'd131072));
    n = 0;
    while (!((cmd_cnt - base) == 3 && m_put_cmd_valid) && n < 30) begin
      tick();
      n++;
    end
    chk("t7_reach_issue", 160'(m_put_cmd_valid), 160'd1);
    chk("t7_ncmd3", 160'(cmd_cnt - base), 160'd3);
    d0 = done_cnt;
    rst = 1'b1;
    #1;
    chk("t7_rst_valid", 160'(m_put_cmd_valid), 160'd0);
    chk("t7_rst_busy", 160'(busy), 160'd0);
    chk("t7_rst_ready", 160'(s_req_ready), 160'd0);
    chk("t7_rst_done", 160'(req_done), 160'd0);
    chk("t7_rst_status", 160'(status_reg), 160'd0);
    repeat (3) tick();
    rst = 1'b0;
    chk("t7_rel_ready_low", 160'(s_req_ready), 160'd0);
    tick();
    chk("t7_rel_ready_high", 160'(s_req_ready), 160'd1);
    chk("t7_no_done", 160'(done_cnt - d0), 160'd0);
    auto_sts = 1'b1;
    base = cmd_cnt;
    send_req(cmd(1'b0, 63'h0, 64'h0, 32'd8192));
    wait_done("t7_new_done", 60);
    chk("t7_new_ncmd", 160'(cmd_cnt - base), 160'd2);
    chk("t7_new_cmd1", cmd_log[base + 1], cmd(1'b0, 63'h1000, 64'h1000, 32'd4096));
    chk("t7_new_issued", 160'(status_reg[0]), 160'd2);

    // Spurious status beat with nothing outstanding counts as an error.
    auto_sts = 1'b0;
    s_mem_sts_valid = 1'b1;
    s_mem_sts_error = 1'b0;
    tick();
    s_mem_sts_valid = 1'b0;
    tick();
    chk("t8_spurious_err", 160'(status_reg[1]), 160'd1);
    chk("t8_idle", 160'(busy), 160'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
